ninjakun_spchr_fetch: RTL and testbench



---
 rtl/ninjakun_spchr_fetch.sv | 146 ++++++++++++++
 tb/tb_ninjakun_spchr_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ninjakun_spchr_fetch.sv
// Sprite CHR ROM fetch sequencer: one ROM fetch per SPCFT slot, data handed to the sprite engine on SPCDT.
// Define NINJAKUN_SPCHR_CACHE_EN to add a one-entry address/data cache that skips repeated fetches.
module ninjakun_spchr_fetch #(
    parameter int unsigned SLOT_CYC = 4
) (
    input  logic        VCLKx4,
    input  logic        RESET_N,
    input  logic [13:0] SPCAD,
    output logic [31:0] SPCDT,
    output logic        SPCFT,
    output logic [13:0] ROM_ADDR,
    output logic        ROM_REQ,
    input  logic        ROM_ACK,
    input  logic [31:0] ROM_DATA
);

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0] SLOT_MAX  = {CW{1'b1}};
    localparam logic [AW-1:0] ADDR_RST  = {AW{1'b1}};

    typedef enum logic [1:0] {
        ST_CAPT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_PULSE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] slot_cnt_q, slot_cnt_d, slot_inc;
    logic [DW-1:0] buf_q, buf_d;
    logic [DW-1:0] spcdt_q, spcdt_d;
    logic          spcft_q, spcft_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          rom_req_q, rom_req_d;

`ifdef NINJAKUN_SPCHR_CACHE_EN
    logic          cache_vld_q, cache_vld_d;
    logic [AW-1:0] cache_addr_q, cache_addr_d;
    logic [DW-1:0] cache_data_q, cache_data_d;
    logic          cache_hit;

    assign cache_hit = cache_vld_q && (cache_addr_q == SPCAD);
`endif

    // Saturating slot counter; HOLD releases on the cycle whose count reaches the slot length.
    assign slot_inc = (slot_cnt_q == SLOT_MAX) ? SLOT_MAX : slot_cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_inc;
        buf_d      = buf_q;
        spcdt_d    = spcdt_q;
        spcft_d    = 1'b0;
        rom_addr_d = rom_addr_q;
        rom_req_d  = rom_req_q;
`ifdef NINJAKUN_SPCHR_CACHE_EN
        cache_vld_d  = cache_vld_q;
        cache_addr_d = cache_addr_q;
        cache_data_d = cache_data_q;
`endif
        unique case (state_q)
            ST_CAPT: begin
                rom_addr_d = SPCAD;
`ifdef NINJAKUN_SPCHR_CACHE_EN
                if (cache_hit) begin
                    buf_d   = cache_data_q;
                    state_d = ST_HOLD;
                end else begin
                    rom_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
`else
                rom_req_d = 1'b1;
                state_d   = ST_REQ;
`endif
            end
            ST_REQ: begin
                if (ROM_ACK) begin
                    buf_d     = ROM_DATA;
                    rom_req_d = 1'b0;
                    state_d   = ST_HOLD;
`ifdef NINJAKUN_SPCHR_CACHE_EN
                    cache_vld_d  = 1'b1;
                    cache_addr_d = rom_addr_q;
                    cache_data_d = ROM_DATA;
`endif
                end
            end
            ST_HOLD: begin
                if (slot_inc >= SLOT_LAST) begin
                    spcdt_d = buf_q;
                    spcft_d = 1'b1;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                slot_cnt_d = '0;
                state_d    = ST_CAPT;
            end
            default: state_d = ST_CAPT;
        endcase
    end

    always_ff @(posedge VCLKx4 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_CAPT;
            slot_cnt_q <= '0;
            buf_q      <= '0;
            spcdt_q    <= '0;
            spcft_q    <= 1'b0;
            rom_addr_q <= ADDR_RST;
            rom_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            buf_q      <= buf_d;
            spcdt_q    <= spcdt_d;
            spcft_q    <= spcft_d;
            rom_addr_q <= rom_addr_d;
            rom_req_q  <= rom_req_d;
        end
    end

`ifdef NINJAKUN_SPCHR_CACHE_EN
    always_ff @(posedge VCLKx4 or negedge RESET_N) begin
        if (!RESET_N) begin
            cache_vld_q  <= 1'b0;
            cache_addr_q <= '0;
            cache_data_q <= '0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_addr_q <= cache_addr_d;
            cache_data_q <= cache_data_d;
        end
    end
`endif

    assign SPCDT    = spcdt_q;
    assign SPCFT    = spcft_q;
    assign ROM_ADDR = rom_addr_q;
    assign ROM_REQ  = rom_req_q;

endmodule

// File: tb/tb_ninjakun_spchr_fetch.sv
// Randomized bench for ninjakun_spchr_fetch: ROM responder, sprite-engine model and slot-timing reference.
// Two instances: SLOT_CYC=4 with variable ROM latency, SLOT_CYC=7 with zero-wait ROM.
module tb_ninjakun_spchr_fetch;

    localparam int unsigned SLOT  = 4;
    localparam int unsigned SLOT7 = 7;
`ifdef NINJAKUN_SPCHR_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [13:0] spcad;
    logic [31:0] spcdt;
    logic        spcft;
    logic [13:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [31:0] rom_data;

    logic [13:0] spcad7;
    logic [31:0] spcdt7;
    logic        spcft7;
    logic [13:0] rom_addr7;
    logic        rom_req7;
    logic        rom_ack7;
    logic [31:0] rom_data7;
    logic        spur7;
    logic [31:0] junk7;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus controls
    bit          fixed_data = 1'b1;
    bit          wait_rand  = 1'b0;
    int          wait_fix   = 0;
    bit          spur_en    = 1'b0;
    int          addr_mode  = 0;
    bit          pend       = 1'b0;
    logic [13:0] pend_addr  = '0;

    // Reference model state
    bit          mon_en    = 1'b0;
    logic [13:0] cur_addr  = '0;
    logic [31:0] last_dt   = '0;
    int          last_pulse = 0;
    int          last_w    = 0;
    int          req_cnt   = 0;
    int          npulse    = 0;
    bit          prev_ft   = 1'b0;
    bit          cache_v   = 1'b0;
    logic [13:0] cache_a   = '0;
    logic [31:0] cache_d   = '0;

    // Responder state
    bit active = 1'b0;
    int k      = 0;
    int w_tgt  = 0;

    bit have7 = 1'b0;
    int last7 = 0;

    function automatic logic [31:0] rom_tag(input logic [13:0] a);
        return {2'b10, a, 2'b01, a ^ 14'h2AAA};
    endfunction

    function automatic logic [31:0] rom_fn(input logic [13:0] a, input bit fixed);
        return fixed ? 32'hA5A5_0001 : rom_tag(a);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    ninjakun_spchr_fetch #(.SLOT_CYC(SLOT)) dut (
        .VCLKx4  (clk),
        .RESET_N (rst_n),
        .SPCAD   (spcad),
        .SPCDT   (spcdt),
        .SPCFT   (spcft),
        .ROM_ADDR(rom_addr),
        .ROM_REQ (rom_req),
        .ROM_ACK (rom_ack),
        .ROM_DATA(rom_data)
    );

    ninjakun_spchr_fetch #(.SLOT_CYC(SLOT7)) dut7 (
        .VCLKx4  (clk),
        .RESET_N (rst_n),
        .SPCAD   (spcad7),
        .SPCDT   (spcdt7),
        .SPCFT   (spcft7),
        .ROM_ADDR(rom_addr7),
        .ROM_REQ (rom_req7),
        .ROM_ACK (rom_ack7),
        .ROM_DATA(rom_data7)
    );

    // Zero-wait ROM for the slow-slot instance, plus stray acks while idle.
    assign rom_ack7  = rom_req7 | spur7;
    assign rom_data7 = rom_req7 ? rom_tag(rom_addr7) : junk7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ROM responder: per-request wait count, checks address and request hold.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            active  = 1'b0;
            rom_ack = 1'b0;
        end else if (rom_req) begin
            if (!active) begin
                active = 1'b1;
                k      = 0;
                w_tgt  = wait_rand ? int'($urandom_range(5, 0)) : wait_fix;
                req_cnt++;
            end
            if (k == w_tgt) begin
                chk("rom_addr", 32'(rom_addr), 32'(cur_addr));
                rom_ack  = 1'b1;
                rom_data = rom_fn(rom_addr, fixed_data);
                last_w   = k;
                active   = 1'b0;
            end else begin
                rom_ack  = 1'b0;
                rom_data = $urandom;
                k++;
            end
        end else begin
            if (active) begin
                chk("rom_req_held", 32'(rom_req), 32'd1);
                active = 1'b0;
            end
            rom_ack  = spur_en && ($urandom_range(2, 0) == 0);
            rom_data = $urandom;
        end
    end

    // Engine model and slot reference for the SLOT_CYC=4 instance.
    initial forever begin
        logic        hit;
        logic [31:0] exp;
        logic [13:0] nxt;
        int          per;
        @(negedge clk);
        if (mon_en && rst_n) begin
            if (prev_ft) chk("spcft_width", 32'(spcft), 32'd0);
            prev_ft = spcft;
            if (spcft) begin
                hit = CACHE_EN && cache_v && (cache_a == cur_addr);
                exp = hit ? cache_d : rom_fn(cur_addr, fixed_data);
                per = hit ? imax(SLOT, 3) : imax(SLOT, 4 + last_w);
                chk("period", 32'(cyc - last_pulse), 32'(per));
                chk("req_per_slot", 32'(req_cnt), hit ? 32'd0 : 32'd1);
                chk("spcdt", spcdt, exp);
                cache_v    = 1'b1;
                cache_a    = cur_addr;
                cache_d    = exp;
                last_dt    = exp;
                last_pulse = cyc;
                req_cnt    = 0;
                npulse++;
                if (pend) begin
                    nxt  = pend_addr;
                    pend = 1'b0;
                end else if (addr_mode == 0) nxt = cur_addr;
                else if (addr_mode == 1) nxt = cur_addr + 14'd8;
                else nxt = 14'($urandom);
                @(posedge clk);
                #1;
                spcad    = nxt;
                cur_addr = nxt;
            end else begin
                chk("spcdt_stable", spcdt, last_dt);
            end
        end
    end

    // Engine model and slot reference for the SLOT_CYC=7 instance.
    initial forever begin
        @(negedge clk);
        spur7 = spur_en && ($urandom_range(2, 0) == 0);
        junk7 = $urandom;
        if (!rst_n) begin
            have7 = 1'b0;
        end else if (spcft7) begin
            if (have7) chk("period7", 32'(cyc - last7), 32'(SLOT7));
            chk("spcdt7", spcdt7, rom_tag(spcad7));
            have7 = 1'b1;
            last7 = cyc;
            @(posedge clk);
            #1;
            spcad7 = 14'($urandom);
        end
    end

    task automatic release_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        last_pulse = cyc - 1;
        last_dt    = '0;
        req_cnt    = 0;
        cache_v    = 1'b0;
        prev_ft    = 1'b0;
        mon_en     = 1'b1;
    endtask

    task automatic wait_pulses(input int n);
        int tgt;
        tgt = npulse + n;
        for (int i = 0; i < 40 * n; i++) begin
            @(negedge clk);
            if (npulse >= tgt) break;
        end
        if (npulse < tgt) chk("pulse_timeout", 32'(npulse), 32'(tgt));
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        rom_ack  = 1'b0;
        rom_data = '0;
        spur7    = 1'b0;
        junk7    = '0;
        spcad    = 14'h0123;
        cur_addr = 14'h0123;
        spcad7   = 14'h0777;
        repeat (3) @(negedge clk);
        chk("rst_spcdt", spcdt, 32'd0);
        chk("rst_spcft", 32'(spcft), 32'd0);
        chk("rst_rom_req", 32'(rom_req), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h3fff);
        chk("rst_rom_req7", 32'(rom_req7), 32'd0);
        chk("rst_rom_addr7", 32'(rom_addr7), 32'h3fff);
        release_reset();

        // Held address, fixed ROM word, zero-wait ack
        wait_pulses(3);

        // Address steps by 8 from 0x0010, address-tagged ROM data
        fixed_data = 1'b0;
        pend_addr  = 14'h0010;
        pend       = 1'b1;
        addr_mode  = 1;
        wait_pulses(6);

        // Five-cycle ROM latency stretches the slot to nine cycles
        wait_fix = 5;
        wait_pulses(4);

        // Random latency, random addresses, stray acks while idle
        wait_rand = 1'b1;
        spur_en   = 1'b1;
        addr_mode = 2;
        wait_pulses(40);

        // Reset while a request is outstanding
        wait_rand = 1'b0;
        wait_fix  = 5;
        spur_en   = 1'b0;
        addr_mode = 1;
        wait_pulses(1);
        n = 0;
        for (int i = 0; i < 200 && n < 2; i++) begin
            @(posedge clk);
            #1;
            n = rom_req ? n + 1 : 0;
        end
        chk("req_seen", 32'(n), 32'd2);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midreq_rom_req", 32'(rom_req), 32'd0);
        chk("midreq_spcft", 32'(spcft), 32'd0);
        chk("midreq_spcdt", spcdt, 32'd0);
        chk("midreq_rom_addr", 32'(rom_addr), 32'h3fff);
        spcad    = 14'h1abc;
        cur_addr = 14'h1abc;
        repeat (3) @(negedge clk);
        release_reset();
        wait_pulses(4);

        // Held address 0x0200 with zero-wait ROM
        wait_fix  = 0;
        pend_addr = 14'h0200;
        pend      = 1'b1;
        addr_mode = 0;
        wait_pulses(8);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
